// File: rtl/program_loader_if.sv
// Host byte-stream link into the program loader: a valid/ready byte channel.
// A byte transfers on any rising edge where byte_valid and byte_ready are both 1;
// the host holds byte_data stable while byte_valid is high and byte_ready is low.
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: takes a length-prefixed little-endian byte stream, writes
// 32-bit words into the core's instruction memory, then releases the core.
module program_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot,
  program_loader_if.slave       host,
  output logic                  ld_en,
  output logic [WORD_WIDTH-1:0] Load_data,
  output logic                  rst_counter,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLR1   = 4'd1,
    LEN_LO = 4'd2,
    LEN_HI = 4'd3,
    DATA   = 4'd4,
    WRITE  = 4'd5,
    CLR2   = 4'd6,
    RUN    = 4'd7,
    ERROR  = 4'd8
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;
  logic [15:0] len_full;
  logic        xfer;

  assign xfer     = host.byte_valid & host.byte_ready;
  assign len_full = {host.byte_data, len[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len          <= '0;
      byte_idx     <= '0;
      word_lo      <= '0;
      Load_data    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERROR: begin
          if (boot) state <= CLR1;
        end
        CLR1: begin
          words_loaded <= '0;
          byte_idx     <= '0;
          len          <= '0;
          state        <= LEN_LO;
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= host.byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= host.byte_data;
            if (len_full == 16'd0 || len_full > MAX_N) state <= ERROR;
            else                                       state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            // Load_data only moves when the fourth byte completes a word.
            case (byte_idx)
              2'd0:    word_lo[7:0]   <= host.byte_data;
              2'd1:    word_lo[15:8]  <= host.byte_data;
              2'd2:    word_lo[23:16] <= host.byte_data;
              default: begin
                Load_data <= {host.byte_data, word_lo};
                state     <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == len) state <= CLR2;
          else                             state <= DATA;
        end
        CLR2:    state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign host.byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign ld_en           = (state == WRITE);
  assign rst_counter     = (state == CLR1) || (state == CLR2);
  assign rd_en           = (state == RUN);
  assign done            = (state == RUN);
  assign err             = (state == ERROR);
  assign busy            = !((state == IDLE) || (state == RUN) || (state == ERROR));
  assign state_dbg       = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized byte streams scored against a word-level
// model of the load protocol, plus cycle-timing and reset checks.
module tb_program_loader;
  localparam int MAXW = 256;

  logic        clk;
  logic        rst_n;
  logic        boot;
  logic        ld_en;
  logic [31:0] Load_data;
  logic        rst_counter;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [3:0]  state_dbg;

  program_loader_if bus ();

  program_loader #(.WORD_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .boot         (boot),
    .host         (bus.slave),
    .ld_en        (ld_en),
    .Load_data    (Load_data),
    .rst_counter  (rst_counter),
    .rd_en        (rd_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] stim_words[$];
  int          rc_cyc[$];
  int          checks = 0;
  int          passes = 0;
  int          ld_count = 0;
  int          last_ld_cyc = -1;
  int          rd_rise_cyc = -1;
  int          e0_cyc = 0;
  logic        rd_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ld_en) begin
        ld_count++;
        last_ld_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_ld_en", 32'd1, 32'd0);
        else                   check("load_data", Load_data, exp_q.pop_front());
        check("ld_en_exclusive", {29'd0, bus.byte_ready, rd_en, rst_counter}, 32'd0);
      end
      if (rst_counter) begin
        rc_cyc.push_back(cyc);
        check("rst_counter_vs_rd_en", {31'd0, rd_en}, 32'd0);
      end
      if (rd_en && !rd_prev) rd_rise_cyc = cyc;
      rd_prev = rd_en;
    end else begin
      rd_prev = 1'b0;
    end
  end

  // ---------------- driver ----------------
  function automatic int pick_gap(input int max_gap);
    if (max_gap == 0) return 0;
    return int'($urandom_range(0, max_gap));
  endfunction

  // Called and returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (!bus.byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("byte_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  // Reference model: a legal header n yields exactly the stim words, in order,
  // then a running core; an illegal header yields err and no writes.
  task automatic run_load(input int n, input int max_gap, input bit hold);
    bit ok;
    int ld0;
    int t;
    ok = (n >= 1 && n <= MAXW);
    if (ok) foreach (stim_words[i]) exp_q.push_back(stim_words[i]);
    ld0 = ld_count;
    rc_cyc.delete();
    rd_rise_cyc = -1;
    @(negedge clk);
    boot   = 1'b1;
    e0_cyc = cyc + 1;
    @(negedge clk);
    if (!hold) boot = 1'b0;
    send_byte(8'(n & 255), pick_gap(max_gap));
    send_byte(8'((n >> 8) & 255), pick_gap(max_gap));
    if (ok) begin
      foreach (stim_words[i])
        for (int k = 0; k < 4; k++)
          send_byte(8'((stim_words[i] >> (8 * k)) & 32'hFF), pick_gap(max_gap));
    end
    t = 0;
    while (!(done || err) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #1;
    check("load_end_timeout", {31'd0, t < 3000}, 32'd1);
    check("err", {31'd0, err}, {31'd0, !ok});
    check("done", {31'd0, done}, {31'd0, ok});
    check("rd_en", {31'd0, rd_en}, {31'd0, ok});
    check("words_loaded", {16'd0, words_loaded}, ok ? 32'(n) : 32'd0);
    check("ld_pulses", 32'(ld_count - ld0), ok ? 32'(n) : 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_outputs"}, {25'd0, bus.byte_ready, ld_en, rst_counter, rd_en, busy, done, err}, 32'd0);
    check({tag, "_load_data"}, Load_data, 32'd0);
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    check({tag, "_state"}, {28'd0, state_dbg}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n          = 1'b0;
    boot           = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #3;
    check_all_clear("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed N=3 load, back-to-back bytes, with cycle timing.
    stim_words = '{32'h00100013, 32'h000000B3, 32'h0000006F};
    run_load(3, 0, 1'b0);
    check("rd_en_cycle", 32'(rd_rise_cyc - e0_cyc + 1), 32'd20);
    check("rst_counter_pulses", 32'(rc_cyc.size()), 32'd2);
    if (rc_cyc.size() == 2) begin
      check("rst_counter_first_cycle", 32'(rc_cyc[0] - e0_cyc + 1), 32'd1);
      check("rst_counter_after_last_write", 32'(rc_cyc[1] - last_ld_cyc), 32'd1);
    end
    check("last_write_cycle", 32'(last_ld_cyc - e0_cyc + 1), 32'd18);

    // Same program with random host gaps.
    run_load(3, 5, 1'b0);

    // Bad headers, each followed by a good load.
    stim_words.delete();
    run_load(0, 2, 1'b0);
    check("rd_en_never_rose_n0", 32'(rd_rise_cyc), 32'hFFFFFFFF);
    run_load(257, 2, 1'b0);
    check("rd_en_never_rose_n257", 32'(rd_rise_cyc), 32'hFFFFFFFF);
    stim_words = '{32'hDEADBEEF, 32'h01234567};
    run_load(2, 3, 1'b0);

    // Randomized programs.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 8));
      stim_words.delete();
      for (int i = 0; i < n; i++) stim_words.push_back($urandom);
      run_load(n, 4, 1'b0);
    end

    // boot held high: load completes, then RUN restarts immediately.
    stim_words = '{32'hA5A5_0001, 32'h5A5A_0002};
    run_load(2, 1, 1'b1);
    @(negedge clk);
    #1;
    check("restart_rst_counter", {31'd0, rst_counter}, 32'd1);
    check("restart_rd_en_drop", {31'd0, rd_en}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    boot = 1'b0;
    pulse_reset();

    // Reset pulled low after 6 bytes (header + one word).
    stim_words = '{32'h11223344};
    exp_q.push_back(32'h11223344);
    @(negedge clk);
    boot = 1'b1;
    @(negedge clk);
    boot = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(8'((stim_words[0] >> (8 * k)) & 32'hFF), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_clear("midload_reset");
    check("midload_exp_q_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-size program with incrementing words.
    stim_words.delete();
    for (int i = 0; i < MAXW; i++) stim_words.push_back(32'(i));
    run_load(MAXW, 0, 1'b0);
    check("max_last_word", Load_data, 32'h000000FF);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the single-cycle RV32 core: the writer side of the core's instruction-load port. It accepts a byte stream from a host link, assembles little-endian 32-bit words, and writes them into instruction memory through `ld_en`/`Load_data`. It manages the core's PC reset (`rst_counter`) around the load, then releases the core into execution by asserting `rd_en`.

## Interface
- `WORD_WIDTH`, 32: instruction word width. Only 32 is supported.
- `MAX_WORDS`, 256: largest accepted program length in words. Must be at most 65535.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `boot` input 1: level-sampled request to start a new load.
- `byte_valid` input 1: host byte available.
- `byte_data` input 8: host byte.
- `byte_ready` output 1: loader can accept a byte. A byte transfers on any edge where `byte_valid & byte_ready`.
- `ld_en` output 1: instruction-memory write strobe to the core.
- `Load_data` output WORD_WIDTH: word to write. Stable whenever `ld_en` = 1.
- `rst_counter` output 1: PC reset pulse to the core.
- `rd_en` output 1: core run enable.
- `busy` output 1: load in progress (any state other than IDLE, RUN or ERROR).
- `done` output 1: program loaded and core running.
- `err` output 1: bad length header was received.
- `words_loaded` output 16: count of words written in the current load.

## Operation
- States: IDLE, CLR1, LEN_LO, LEN_HI, DATA, WRITE, CLR2, RUN, ERROR.
- Outputs are decoded from the registered state, except `Load_data` and `words_loaded`, which are registers.
- IDLE: all strobes are 0. If `boot` = 1, go to CLR1.
- CLR1: `rst_counter` = 1 for exactly one cycle. Clear `words_loaded`, the byte index and the length register. Go to LEN_LO.
- LEN_LO: `byte_ready` = 1. On transfer, latch N[7:0]. Go to LEN_HI.
- LEN_HI: `byte_ready` = 1. On transfer, latch N[15:8].
  - If N = 0 or N > `MAX_WORDS`, go to ERROR.
  - Otherwise go to DATA.
- DATA: `byte_ready` = 1. Byte k (k = 0..3) of a word lands in bits [8k+7:8k]. On the 4th transfer, the full word is written to `Load_data` and the state goes to WRITE.
  - `Load_data` changes only at this edge. It holds otherwise, including after the load completes.
- WRITE: `ld_en` = 1 for one cycle; `byte_ready` = 0. Increment `words_loaded`.
  - If the incremented count equals N, go to CLR2; otherwise go to DATA.
  - The core writes memory at the current PC and increments the PC on this same edge.
- CLR2: `rst_counter` = 1 for one cycle, returning the PC to 0. Go to RUN.
- RUN: `rd_en` = 1 and `done` = 1 continuously. If `boot` = 1, go to CLR1; `rd_en` drops when CLR1 is entered.
- ERROR: `err` = 1; `ld_en`, `rd_en` and `byte_ready` are 0. If `boot` = 1, go to CLR1.
- `boot` is ignored in CLR1, LEN_LO, LEN_HI, DATA, WRITE and CLR2. A load cannot be aborted except by `rst`.
- `ld_en` and `rd_en` are never both 1. `rst_counter` is never 1 together with `ld_en` or `rd_en`.
- Bytes offered while `byte_ready` = 0 are not consumed; the host holds them.
- `words_loaded` increments only in WRITE. It saturates at N by construction.

## Timing
- Reset (`rst` = 0, asynchronous): state = IDLE; `byte_ready`, `ld_en`, `rst_counter`, `rd_en`, `busy`, `done`, `err` = 0; `Load_data` = 0; `words_loaded` = 0. Release is synchronous to the next edge.
- Reset asserted mid-load: outputs clear immediately without waiting for a clock. Instruction memory is left partially written. A new `boot` is required.
- Cycle numbering: edge E0 samples `boot` = 1 in IDLE. `rst_counter` is high during cycle 1. `byte_ready` first goes high in cycle 2.
- Per word: 4 accepted bytes, then 1 WRITE cycle. Back-to-back bytes give 5 cycles per word.
- Load latency: the last WRITE cycle is followed by one CLR2 cycle. `rd_en` goes high in the next cycle.
- Minimum total from `boot` to `rd_en`: 1 + 2 + 5N + 1 cycles, with `rd_en` high in cycle 5N + 5 after E0.

## Test plan
- Load N = 3 words with no gaps: bytes 03 00, then 13 00 10 00, B3 00 00 00, 6F 00 00 00.
  - Expect exactly three `ld_en` pulses, with `Load_data` = 0x00100013, 0x000000B3, 0x0000006F on successive pulses.
  - Expect `rst_counter` pulses immediately before the length bytes and immediately after the last write.
  - Expect `rd_en` high in cycle 20 after E0; `words_loaded` = 3; `done` = 1.
- Same load with random `byte_valid` gaps of 0–5 cycles: identical word sequence, and `ld_en` never coincides with `byte_ready`.
- Length header 00 00, and separately 01 01 (257 > 256): `err` = 1, no `ld_en` pulses, `rd_en` stays 0. A following `boot` restarts and a valid load succeeds.
- `boot` held high throughout the load: the load completes normally. Once RUN is reached, `boot` still high restarts with a `rst_counter` pulse, and `rd_en` falls in that cycle.
- `rst` pulled low after 6 bytes: all outputs are 0 immediately, state is IDLE, and `words_loaded` = 0.
- N = `MAX_WORDS` (256) with an incrementing-word pattern: 256 `ld_en` pulses, the last with `Load_data` = 0x000000FF, then `done` = 1.
